// File: rtl/udp_rx_cmd_parser.sv
// UDP command parser: validates a two-word header, then streams the payload
// words into a BRAM write port. Bad or truncated datagrams are dropped and counted.
module udp_rx_cmd_parser #(
  parameter int          ADDR_W  = 10,
  parameter logic [15:0] MAGIC   = 16'hA55A,
  parameter int          MAX_LEN = 256
) (
  input  logic              sclk,
  input  logic              reset,
  input  logic              axi_rx_tvalid_i,
  output logic              axi_rx_tready_o,
  input  logic [31:0]       axi_rx_tdata_i,
  input  logic [31:0]       axi_rx_tuser_i,
  input  logic [3:0]        axi_rx_tkeep_i,
  input  logic              axi_rx_tlast_i,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_wdata_o,
  output logic [3:0]        ram_be_o,
  output logic              cmd_done_o,
  output logic              cmd_err_o,
  output logic [31:0]       cmd_src_ip_o,
  output logic [7:0]        cmd_opcode_o,
  output logic [15:0]       cmd_words_o,
  output logic [15:0]       pkt_cnt_o,
  output logic [15:0]       err_cnt_o
);

  typedef enum logic [2:0] {S_IDLE, S_HDR1, S_PAYLOAD, S_DROP, S_DONE} state_t;

  localparam logic [16:0] MAX_LEN_C = 17'(MAX_LEN);

  state_t             state_q;
  logic               tready_q;
  logic [ADDR_W-1:0]  ptr_q;
  logic [15:0]        cnt_q;
  logic [15:0]        len_q;
  logic               ram_we_q;
  logic [ADDR_W-1:0]  ram_addr_q;
  logic [31:0]        ram_wdata_q;
  logic [3:0]         ram_be_q;
  logic               done_q;
  logic               err_q;
  logic [31:0]        src_ip_q;
  logic [7:0]         opcode_q;
  logic [15:0]        words_q;
  logic [15:0]        pkt_cnt_q;
  logic [15:0]        err_cnt_q;

  logic               accept_s;
  logic               full_keep_s;
  logic               len_bad_s;
  logic [15:0]        cnt_inc_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign accept_s    = axi_rx_tvalid_i & tready_q;
  assign full_keep_s = (axi_rx_tkeep_i == 4'hF);
  assign len_bad_s   = (axi_rx_tdata_i[15:0] == 16'd0) ||
                       ({1'b0, axi_rx_tdata_i[15:0]} > MAX_LEN_C);
  assign cnt_inc_s   = cnt_q + 16'd1;

  // Parser FSM with all outputs registered; status pulses default low every cycle.
  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      tready_q    <= 1'b1;
      ptr_q       <= '0;
      cnt_q       <= 16'd0;
      len_q       <= 16'd0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= 32'd0;
      ram_be_q    <= 4'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      src_ip_q    <= 32'd0;
      opcode_q    <= 8'd0;
      words_q     <= 16'd0;
      pkt_cnt_q   <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            if (axi_rx_tlast_i) begin
              err_q     <= 1'b1;
              err_cnt_q <= sat_inc(err_cnt_q);
            end else if ((axi_rx_tdata_i[31:16] != MAGIC) || !full_keep_s) begin
              state_q <= S_DROP;
            end else begin
              opcode_q <= axi_rx_tdata_i[15:8];
              src_ip_q <= axi_rx_tuser_i;
              state_q  <= S_HDR1;
            end
          end
        end
        S_HDR1: begin
          if (accept_s) begin
            if (axi_rx_tlast_i) begin
              err_q     <= 1'b1;
              err_cnt_q <= sat_inc(err_cnt_q);
              state_q   <= S_IDLE;
            end else if (len_bad_s || !full_keep_s) begin
              state_q <= S_DROP;
            end else begin
              ptr_q   <= axi_rx_tdata_i[16 +: ADDR_W];
              len_q   <= axi_rx_tdata_i[15:0];
              cnt_q   <= 16'd0;
              state_q <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (accept_s) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= ptr_q;
            ram_wdata_q <= axi_rx_tdata_i;
            ram_be_q    <= axi_rx_tkeep_i;
            ptr_q       <= ptr_q + ADDR_W'(1);
            cnt_q       <= cnt_inc_s;
            // done is raised here so it lands on the same cycle as the final write
            if (cnt_inc_s == len_q) begin
              if (axi_rx_tlast_i) begin
                done_q    <= 1'b1;
                words_q   <= len_q;
                pkt_cnt_q <= sat_inc(pkt_cnt_q);
                tready_q  <= 1'b0;
                state_q   <= S_DONE;
              end else begin
                state_q <= S_DROP;
              end
            end else if (axi_rx_tlast_i) begin
              err_q     <= 1'b1;
              err_cnt_q <= sat_inc(err_cnt_q);
              state_q   <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (accept_s && axi_rx_tlast_i) begin
            err_q     <= 1'b1;
            err_cnt_q <= sat_inc(err_cnt_q);
            state_q   <= S_IDLE;
          end
        end
        S_DONE: begin
          tready_q <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          tready_q <= 1'b1;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign axi_rx_tready_o = tready_q;
  assign ram_we_o        = ram_we_q;
  assign ram_addr_o      = ram_addr_q;
  assign ram_wdata_o     = ram_wdata_q;
  assign ram_be_o        = ram_be_q;
  assign cmd_done_o      = done_q;
  assign cmd_err_o       = err_q;
  assign cmd_src_ip_o    = src_ip_q;
  assign cmd_opcode_o    = opcode_q;
  assign cmd_words_o     = words_q;
  assign pkt_cnt_o       = pkt_cnt_q;
  assign err_cnt_o       = err_cnt_q;

endmodule

// File: tb/tb_udp_rx_cmd_parser.sv
// Directed bench for udp_rx_cmd_parser: drives datagrams beat by beat and
// compares the collected BRAM writes and status against hand-computed values.
module tb_udp_rx_cmd_parser;

  localparam int ADDR_W = 10;

  logic              sclk;
  logic              reset;
  logic              tvalid;
  logic              tready;
  logic [31:0]       tdata;
  logic [31:0]       tuser;
  logic [3:0]        tkeep;
  logic              tlast;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic [3:0]        ram_be;
  logic              cmd_done;
  logic              cmd_err;
  logic [31:0]       cmd_src_ip;
  logic [7:0]        cmd_opcode;
  logic [15:0]       cmd_words;
  logic [15:0]       pkt_cnt;
  logic [15:0]       err_cnt;

  int checks = 0;
  int errors = 0;

  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic [3:0]        wb[$];
  logic [ADDR_W-1:0] ref_a[$];
  logic [31:0]       ref_d[$];
  int done_n = 0;
  int err_n = 0;
  int done_at = -1;
  int done_we = 0;

  udp_rx_cmd_parser #(.ADDR_W(ADDR_W), .MAGIC(16'hA55A), .MAX_LEN(256)) dut (
    .sclk            (sclk),
    .reset           (reset),
    .axi_rx_tvalid_i (tvalid),
    .axi_rx_tready_o (tready),
    .axi_rx_tdata_i  (tdata),
    .axi_rx_tuser_i  (tuser),
    .axi_rx_tkeep_i  (tkeep),
    .axi_rx_tlast_i  (tlast),
    .ram_we_o        (ram_we),
    .ram_addr_o      (ram_addr),
    .ram_wdata_o     (ram_wdata),
    .ram_be_o        (ram_be),
    .cmd_done_o      (cmd_done),
    .cmd_err_o       (cmd_err),
    .cmd_src_ip_o    (cmd_src_ip),
    .cmd_opcode_o    (cmd_opcode),
    .cmd_words_o     (cmd_words),
    .pkt_cnt_o       (pkt_cnt),
    .err_cnt_o       (err_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Collect writes and status pulses mid-cycle, away from the active edge.
  always @(negedge sclk) begin
    if (ram_we) begin
      wa.push_back(ram_addr);
      wd.push_back(ram_wdata);
      wb.push_back(ram_be);
    end
    if (cmd_done) begin
      done_n++;
      done_at = wa.size();
      done_we = int'(ram_we);
    end
    if (cmd_err) err_n++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    wa.delete(); wd.delete(); wb.delete();
    done_n = 0; err_n = 0; done_at = -1; done_we = 0;
  endtask

  // Present one beat, wait for acceptance, then leave a gap of idle cycles.
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l, input int gap);
    int n = 0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    while (!tready && n < 50) begin
      @(negedge sclk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL beat_timeout: observed tready stuck low expected acceptance");
    end
    @(negedge sclk);
    tvalid = 1'b0; tlast = 1'b0;
    repeat (gap) @(negedge sclk);
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    repeat (n) @(negedge sclk);
  endtask

  initial begin
    reset = 1'b0; tvalid = 1'b0; tdata = 32'd0; tuser = 32'd0; tkeep = 4'h0; tlast = 1'b0;
    repeat (3) @(negedge sclk);
    chk("rst_tready", tready, 1'b1);
    chk("rst_we", ram_we, 1'b0);
    chk("rst_done", cmd_done, 1'b0);
    chk("rst_err", cmd_err, 1'b0);
    chk("rst_pkt", pkt_cnt, 16'd0);
    chk("rst_errcnt", err_cnt, 16'd0);
    chk("rst_words", cmd_words, 16'd0);
    chk("rst_src", cmd_src_ip, 32'd0);
    reset = 1'b1;
    idle(2);

    // Good datagram: base 0x010, 3 words
    clr();
    tuser = 32'hC0A8_0001;
    beat(32'hA55A_0100, 4'hF, 1'b0, 0);
    beat(32'h0010_0003, 4'hF, 1'b0, 0);
    beat(32'h1111_1111, 4'hF, 1'b0, 0);
    beat(32'h2222_2222, 4'h3, 1'b0, 0);
    beat(32'h3333_3333, 4'hF, 1'b1, 0);
    chk("good_done_pulse", cmd_done, 1'b1);
    chk("good_tready_done", tready, 1'b0);
    idle(3);
    chk("good_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("good_a0", wa[0], 10'h010);
      chk("good_a1", wa[1], 10'h011);
      chk("good_a2", wa[2], 10'h012);
      chk("good_d0", wd[0], 32'h1111_1111);
      chk("good_d1", wd[1], 32'h2222_2222);
      chk("good_d2", wd[2], 32'h3333_3333);
      chk("good_be1", wb[1], 4'h3);
    end
    chk("good_done_n", done_n, 1);
    chk("good_done_at", done_at, 3);
    chk("good_done_we", done_we, 1);
    chk("good_words", cmd_words, 16'd3);
    chk("good_opcode", cmd_opcode, 8'h01);
    chk("good_src", cmd_src_ip, 32'hC0A8_0001);
    chk("good_pkt", pkt_cnt, 16'd1);
    chk("good_errs", err_n, 0);

    // Bad magic then 5 beats ending in tlast
    clr();
    beat(32'h1234_0000, 4'hF, 1'b0, 0);
    for (int i = 0; i < 4; i++) beat(32'h0 + 32'(i), 4'hF, 1'b0, 0);
    beat(32'hFFFF_FFFF, 4'hF, 1'b1, 0);
    chk("magic_err_pulse", cmd_err, 1'b1);
    idle(1);
    chk("magic_err_one", cmd_err, 1'b0);
    idle(2);
    chk("magic_nwr", wa.size(), 0);
    chk("magic_err_n", err_n, 1);
    chk("magic_errcnt", err_cnt, 16'd1);

    // Short datagram: len 4, tlast on 2nd payload word
    clr();
    beat(32'hA55A_0200, 4'hF, 1'b0, 0);
    beat(32'h0020_0004, 4'hF, 1'b0, 0);
    beat(32'h4444_4444, 4'hF, 1'b0, 0);
    beat(32'h5555_5555, 4'hF, 1'b1, 0);
    chk("short_err_pulse", cmd_err, 1'b1);
    idle(3);
    chk("short_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("short_a1", wa[1], 10'h021);
      chk("short_d1", wd[1], 32'h5555_5555);
    end
    chk("short_done_n", done_n, 0);
    chk("short_errcnt", err_cnt, 16'd2);
    chk("short_pkt", pkt_cnt, 16'd1);

    // Long datagram with address wrap at 0x3FF
    clr();
    beat(32'hA55A_0300, 4'hF, 1'b0, 0);
    beat(32'h03FF_0002, 4'hF, 1'b0, 0);
    beat(32'h6666_6666, 4'hF, 1'b0, 0);
    beat(32'h7777_7777, 4'hF, 1'b0, 0);
    beat(32'h8888_8888, 4'hF, 1'b0, 0);
    beat(32'h9999_9999, 4'hF, 1'b1, 0);
    chk("wrap_err_pulse", cmd_err, 1'b1);
    idle(3);
    chk("wrap_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("wrap_a0", wa[0], 10'h3FF);
      chk("wrap_a1", wa[1], 10'h000);
      chk("wrap_d1", wd[1], 32'h7777_7777);
    end
    chk("wrap_done_n", done_n, 0);
    chk("wrap_errcnt", err_cnt, 16'd3);

    // Header boundaries: len 0, len MAX_LEN+1, tlast on word0
    clr();
    beat(32'hA55A_0400, 4'hF, 1'b0, 0);
    beat(32'h0000_0000, 4'hF, 1'b0, 0);
    beat(32'hDEAD_BEEF, 4'hF, 1'b1, 0);
    beat(32'hA55A_0500, 4'hF, 1'b0, 0);
    beat(32'h0000_0101, 4'hF, 1'b0, 0);
    beat(32'hCAFE_F00D, 4'hF, 1'b1, 0);
    beat(32'hA55A_0600, 4'hF, 1'b1, 0);
    chk("w0last_err_pulse", cmd_err, 1'b1);
    idle(3);
    chk("hdr_nwr", wa.size(), 0);
    chk("hdr_errcnt", err_cnt, 16'd6);
    chk("hdr_opcode", cmd_opcode, 8'h05);
    chk("hdr_words_kept", cmd_words, 16'd3);

    // Reset in the middle of a payload
    clr();
    beat(32'hA55A_0100, 4'hF, 1'b0, 0);
    beat(32'h0040_0003, 4'hF, 1'b0, 0);
    beat(32'h1212_1212, 4'hF, 1'b0, 0);
    #1;
    chk("rstmid_we_before", ram_we, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_we_async", ram_we, 1'b0);
    chk("rstmid_tready", tready, 1'b1);
    chk("rstmid_pkt", pkt_cnt, 16'd0);
    chk("rstmid_errcnt", err_cnt, 16'd0);
    @(negedge sclk);
    reset = 1'b1;
    beat(32'hAAAA_0001, 4'hF, 1'b0, 0);
    beat(32'hBBBB_0002, 4'hF, 1'b1, 0);
    chk("rstmid_tail_err", cmd_err, 1'b1);
    idle(3);
    chk("rstmid_tail_errcnt", err_cnt, 16'd1);
    clr();
    tuser = 32'h0A00_0002;
    beat(32'hA55A_0700, 4'hF, 1'b0, 0);
    beat(32'h0050_0003, 4'hF, 1'b0, 0);
    beat(32'hA1A1_A1A1, 4'hF, 1'b0, 0);
    beat(32'hA2A2_A2A2, 4'hF, 1'b0, 0);
    beat(32'hA3A3_A3A3, 4'hF, 1'b1, 0);
    idle(3);
    chk("after_rst_pkt", pkt_cnt, 16'd1);
    chk("after_rst_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("after_rst_a2", wa[2], 10'h052);
      chk("after_rst_d0", wd[0], 32'hA1A1_A1A1);
    end
    chk("after_rst_src", cmd_src_ip, 32'h0A00_0002);
    ref_a = wa;
    ref_d = wd;

    // Same datagram with random tvalid gaps
    clr();
    beat(32'hA55A_0700, 4'hF, 1'b0, $urandom_range(0, 3));
    beat(32'h0050_0003, 4'hF, 1'b0, $urandom_range(0, 3));
    beat(32'hA1A1_A1A1, 4'hF, 1'b0, $urandom_range(1, 3));
    beat(32'hA2A2_A2A2, 4'hF, 1'b0, $urandom_range(1, 3));
    beat(32'hA3A3_A3A3, 4'hF, 1'b1, 0);
    idle(3);
    chk("gap_nwr", wa.size(), 3);
    if (wa.size() == 3 && ref_a.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("gap_addr", wa[i], ref_a[i]);
        chk("gap_data", wd[i], ref_d[i]);
        chk("gap_addr_abs", wa[i], 10'h050 + 10'(i));
      end
    end
    chk("gap_done_n", done_n, 1);
    chk("gap_pkt", pkt_cnt, 16'd2);
    chk("gap_errcnt", err_cnt, 16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_rx_cmd_parser.md
UDP_RX_CMD_PARSER -- requirements
Module: udp_rx_cmd_parser

Interface
REQ-001 Parameter ADDR_W, default 10, BRAM word-address width.
REQ-002 Parameter MAGIC, default 16'hA55A, required header tag.
REQ-003 Parameter MAX_LEN, default 256, maximum payload words per command.
REQ-004 sclk  in  1  single clock; all logic SHALL be on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 axi_rx_tvalid_i / axi_rx_tready_o  in / out  1 / 1  UDP receive stream handshake, fed by udp_top rx_usr_*.
REQ-007 axi_rx_tdata_i  in  32  UDP payload word.
REQ-008 axi_rx_tuser_i  in  32  source IP of the datagram.
REQ-009 axi_rx_tkeep_i  in  4  byte enables.
REQ-010 axi_rx_tlast_i  in  1  last beat of the datagram.
REQ-011 ram_we_o, ram_addr_o, ram_wdata_o, ram_be_o  out  1, ADDR_W, 32, 4  BRAM write port.
REQ-012 cmd_done_o, cmd_err_o  out  1, 1  single-cycle status pulses.
REQ-013 cmd_src_ip_o, cmd_opcode_o, cmd_words_o  out  32, 8, 16  fields of the last command.
REQ-014 pkt_cnt_o, err_cnt_o  out  16, 16  good and bad datagram counters.

Function
REQ-015 A beat SHALL be accepted only on a cycle where axi_rx_tvalid_i and axi_rx_tready_o are both 1.
REQ-016 Datagram format SHALL be: word0 = {MAGIC[31:16], opcode[15:8], rsvd[7:0]}; word1 = {base_addr[31:16], len_words[15:0]}; followed by len_words payload words.
REQ-017 FSM states SHALL be IDLE, HDR1, PAYLOAD, DROP and DONE; axi_rx_tready_o SHALL be 1 in every state except DONE.
REQ-018 IDLE, on an accepted beat: if tlast=1, flag an error and stay in IDLE; else if tdata[31:16]!=MAGIC or tkeep!=4'hF, go to DROP; else latch opcode and tuser into cmd_opcode_o/cmd_src_ip_o and go to HDR1.
REQ-019 HDR1, on an accepted beat: if tlast=1, flag an error and go to IDLE; else if len=0, len>MAX_LEN or tkeep!=4'hF, go to DROP; else load the address pointer with base_addr[ADDR_W-1:0], clear the word count and go to PAYLOAD.
REQ-020 PAYLOAD, on each accepted beat: register one BRAM write of tdata/tkeep at the pointer, then increment the pointer modulo 2^ADDR_W (wraps, no error) and increment the count.
REQ-021 PAYLOAD exit when count+1=len: if tlast=1, go to DONE; else go to DROP.
REQ-022 PAYLOAD with tlast=1 and count+1<len SHALL flag an error and go to IDLE; the words already written remain in BRAM.
REQ-023 DROP SHALL discard beats until an accepted tlast, then flag an error and go to IDLE.
REQ-024 DONE SHALL last exactly one cycle: cmd_done_o=1, cmd_words_o=len, pkt_cnt_o increments; then go to IDLE.
REQ-025 Flagging an error SHALL pulse cmd_err_o for one cycle, starting the cycle after the terminating beat, and SHALL increment err_cnt_o.
REQ-026 Write latency SHALL be 1 cycle: ram_we_o/ram_addr_o/ram_wdata_o/ram_be_o are valid on the cycle after the beat is accepted.
REQ-027 ram_we_o SHALL be 0 in every cycle that does not follow an accepted PAYLOAD beat.
REQ-028 cmd_done_o SHALL coincide with the write of the final payload word.
REQ-029 Both counters SHALL saturate at 16'hFFFF.
REQ-030 A tvalid stall mid-datagram SHALL hold state and pointer unchanged, with no write.

Reset
REQ-031 reset=0 SHALL immediately force state IDLE and set every output to 0, except axi_rx_tready_o, which SHALL be 1; counters, pointer and latched fields are cleared.
REQ-032 On reset release mid-datagram, the next accepted beat SHALL be parsed as word0; the remainder of the interrupted datagram therefore falls into DROP or the IDLE error path.

Verification
REQ-033 Good datagram: header A55A_0100 and 0010_0003, then 3 payload words with tlast on the third -> writes at addresses 0x010, 0x011, 0x012; cmd_done_o=1 with the last write; cmd_words_o=3; pkt_cnt_o=1.
REQ-034 Bad magic: word0=1234_0000 followed by 5 beats ending in tlast -> no writes; one cmd_err_o pulse after the tlast beat; err_cnt_o=1.
REQ-035 Short datagram: len=4, tlast on the 2nd payload word -> 2 writes; cmd_err_o pulse; no cmd_done_o.
REQ-036 Long datagram plus wrap: ADDR_W=10, base=0x3FF, len=2, 4 payload beats -> writes at 0x3FF then 0x000; the remaining beats are dropped; cmd_err_o pulse.
REQ-037 Reset mid-payload: assert reset=0 after 1 of 3 payload beats -> ram_we_o drops to 0 in the same cycle; after release, the following good datagram completes normally with pkt_cnt_o=1.
REQ-038 Random tvalid gaps on a good datagram: every write address and data value matches the gap-free run.
